pio_in_edge: RTL and testbench
==============================

# pio_in_edge

Avalon-MM slave input port: the read-direction companion of the team's output PIO. Samples a WIDTH-bit external input through a two-flop synchronizer and optional per-bit debounce filter, exposes the filtered level, latches selected edges in a write-1-to-clear capture register, and raises a level interrupt for unmasked captured edges. Sits on the Nios II data master alongside the output PIOs and drives one IRQ line into the CPU interrupt controller.

## Interface
- WIDTH, 2: number of input bits (1..32).
- EDGE_TYPE, 0: edge that sets capture: 0 rising, 1 falling, 2 any.
- DEBOUNCE_CYCLES, 0: consecutive stable cycles required before the filtered level changes; 0 bypasses the filter.

- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt, active high.

## Operation
- Register map (word address):
  - 0 DATA (RO): filtered input level in bits [WIDTH-1:0]; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 IRQMASK (RW): per-bit interrupt enable.
  - 3 EDGECAP (R/W1C): per-bit captured edge flag.
- readdata = zero-extended selected register; depends on address only (chipselect not required); upper 32-WIDTH bits always 0.
- Write occurs when chipselect && !write_n; IRQMASK <= writedata[WIDTH-1:0].
- Input path per bit: sync1 <= in_port; sync2 <= sync1.
- Debounce (DEBOUNCE_CYCLES = D > 0): per-bit counter, width $clog2(D+1).
  - sync2 == filt: counter <= 0.
  - sync2 != filt and counter < D-1: counter increments.
  - sync2 != filt and counter == D-1: filt <= sync2, counter <= 0.
  - D = 0: filt = sync2 (no counter logic).
- Edge detect: filt_d <= filt; rise = filt & ~filt_d; fall = ~filt & filt_d; edge selected by EDGE_TYPE.
- EDGECAP next = (EDGECAP & ~clr) | edge, where clr = writedata[WIDTH-1:0] on a write to address 3, else 0. Set wins over simultaneous clear of the same bit.
- irq <= |(EDGECAP_next & IRQMASK_next) (registered); irq remains high until all unmasked captured bits are cleared or masked.
- Reset values: sync1, sync2, filt, filt_d, counters, IRQMASK, EDGECAP all 0; irq 0; readdata 0 for every address.

## Timing
- in_port bit changes before edge k (meeting setup): sync2 updates at k+1; filt at k+1+D; DATA read reflects new level from edge k+1+D.
- EDGECAP bit sets at edge k+2+D; irq asserts at edge k+2+D if mask bit set.
- Glitch of length L cycles at sync2 with D > 0: rejected if L < D (counter restarts); accepted if L >= D.
- W1C write at edge n: EDGECAP bit 0 and irq low after edge n, unless a new edge on that bit coincides.
- Mask write at edge n: irq reflects new mask after edge n.
- Reset asserted mid-operation: all state clears immediately (asynchronous); the first edge detection after release requires an actual filt transition from 0; an input already high at release produces a rising capture at k+2+D.
- No wait states; single-cycle write acceptance.

## Test plan
- Reset: hold reset_n low with in_port=2'b11 -> irq=0, readdata=0 at every address; release -> DATA reads 2'b11 after 2 cycles (D=0), EDGECAP reads 2'b11 one cycle later.
- Rising capture, D=0, EDGE_TYPE=0, IRQMASK=2'b01: in_port 0->2'b01 before edge k -> DATA=1 from k+1, EDGECAP=1 and irq=1 at k+2; falling back to 0 leaves EDGECAP unchanged.
- W1C and collision: EDGECAP=2'b11, write 2'b01 to address 3 -> reads 2'b10; repeat with a new bit-0 edge in the write cycle -> bit 0 stays 1.
- Masking: EDGECAP=2'b10, IRQMASK=2'b01 -> irq=0; write IRQMASK=2'b10 -> irq=1 next cycle; write 0 -> irq=0.
- Debounce, D=4: 3-cycle high pulse on bit 0 -> DATA and EDGECAP stay 0; 4-cycle pulse -> DATA=1 at k+5, EDGECAP=1 at k+6.
- EDGE_TYPE=2: bit 1 toggles 0->1->0 with clears in between -> capture sets on both transitions; EDGE_TYPE=1 sets only on 1->0.

Source files
------------

// File: rtl/pio_in_edge.sv
// Avalon-MM input PIO: synchronized, optionally debounced inputs with
// selectable edge capture (write-1-to-clear) and a masked level interrupt.
module pio_in_edge #(
  parameter int unsigned WIDTH           = 32'd2,
  parameter int unsigned EDGE_TYPE       = 32'd0,
  parameter int unsigned DEBOUNCE_CYCLES = 32'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] filt_s;
  logic [WIDTH-1:0] filt_d_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] mask_next_s;
  logic [WIDTH-1:0] edgecap_next_s;
  logic             wr_s;
  logic             irq_r;
  logic             unused_wdata_s;

  // Bits above WIDTH are never stored.
  assign unused_wdata_s = ^writedata;

  // Two-flop synchronizer for the asynchronous inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= in_port;
      sync2_r <= sync1_r;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 32'd0) begin : g_no_debounce
      assign filt_s = sync2_r;
    end else begin : g_debounce
      localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 32'd1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 32'd1);
      localparam logic [CW-1:0] ONE  = CW'(32'd1);

      logic [CW-1:0]    cnt_r [WIDTH];
      logic [WIDTH-1:0] filt_r;

      // Per-bit stability counter; any return to the filtered level restarts it.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          filt_r <= '0;
          for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_r[i] <= '0;
          end
        end else begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_r[i] == filt_r[i]) begin
              cnt_r[i] <= '0;
            end else if (cnt_r[i] == LAST) begin
              filt_r[i] <= sync2_r[i];
              cnt_r[i]  <= '0;
            end else begin
              cnt_r[i] <= cnt_r[i] + ONE;
            end
          end
        end
      end

      assign filt_s = filt_r;
    end
  endgenerate

  // Edge selection on the filtered level.
  always_comb begin
    rise_s = filt_s & ~filt_d_r;
    fall_s = ~filt_s & filt_d_r;
    if (EDGE_TYPE == 32'd0) begin
      edge_s = rise_s;
    end else if (EDGE_TYPE == 32'd1) begin
      edge_s = fall_s;
    end else begin
      edge_s = rise_s | fall_s;
    end
  end

  // Register-write decode; a fresh edge wins over a same-cycle clear.
  always_comb begin
    wr_s        = chipselect && !write_n;
    clr_s       = '0;
    mask_next_s = mask_r;
    if (wr_s && (address == 2'd3)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    if (wr_s && (address == 2'd2)) begin
      mask_next_s = writedata[WIDTH-1:0];
    end else begin
      mask_next_s = mask_r;
    end
    edgecap_next_s = (edgecap_r & ~clr_s) | edge_s;
  end

  // Edge history, mask, capture flags and the registered interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_d_r  <= '0;
      mask_r    <= '0;
      edgecap_r <= '0;
      irq_r     <= 1'b0;
    end else begin
      filt_d_r  <= filt_s;
      mask_r    <= mask_next_s;
      edgecap_r <= edgecap_next_s;
      irq_r     <= |(edgecap_next_s & mask_next_s);
    end
  end

  assign irq = irq_r;

  // Read mux, decoded from address alone.
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = filt_s;
      2'd1:    readdata = 32'd0;
      2'd2:    readdata[WIDTH-1:0] = mask_r;
      2'd3:    readdata[WIDTH-1:0] = edgecap_r;
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_pio_in_edge.sv
// Directed bench for pio_in_edge: four instances cover rising/D=0, debounce D=4,
// any-edge and falling-edge capture on a shared Avalon bus.
module tb_pio_in_edge;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_dut, in_deb, in_any, in_fall;
  logic [31:0] rd_dut, rd_deb, rd_any, rd_fall;
  logic        irq_dut, irq_deb, irq_any, irq_fall;

  int checks   = 0;
  int failures = 0;

  pio_in_edge #(.WIDTH(32'd2), .EDGE_TYPE(32'd0), .DEBOUNCE_CYCLES(32'd0)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_dut), .in_port(in_dut), .irq(irq_dut));

  pio_in_edge #(.WIDTH(32'd2), .EDGE_TYPE(32'd0), .DEBOUNCE_CYCLES(32'd4)) u_deb (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_deb), .in_port(in_deb), .irq(irq_deb));

  pio_in_edge #(.WIDTH(32'd2), .EDGE_TYPE(32'd2), .DEBOUNCE_CYCLES(32'd0)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_any), .in_port(in_any), .irq(irq_any));

  pio_in_edge #(.WIDTH(32'd2), .EDGE_TYPE(32'd1), .DEBOUNCE_CYCLES(32'd0)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_fall), .in_port(in_fall), .irq(irq_fall));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sel(input logic [1:0] a);
    address = a;
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;
    in_dut = 2'b11; in_deb = 2'b00; in_any = 2'b00; in_fall = 2'b00;
    tick(3);

    // Reset state with inputs already high
    check("rst_irq", {31'd0, irq_dut}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      sel(2'(a));
      check("rst_rd", rd_dut, 32'd0);
    end
    reset_n = 1'b1;
    tick(1); sel(2'd0);
    check("rel_data_k1", rd_dut, 32'd0);
    tick(1);
    check("rel_data_k2", rd_dut, 32'd3);
    sel(2'd3);
    check("rel_cap_k2", rd_dut, 32'd0);
    tick(1);
    check("rel_cap_k3", rd_dut, 32'd3);
    check("rel_irq_nomask", {31'd0, irq_dut}, 32'd0);

    bus_write(2'd3, 32'd3);
    check("w1c_all", rd_dut, 32'd0);
    in_dut = 2'b00; tick(3);
    check("fall_no_cap", rd_dut, 32'd0);

    // Rising capture with mask on bit 0
    bus_write(2'd2, 32'd1); sel(2'd2);
    check("mask_rd", rd_dut, 32'd1);
    in_dut = 2'b01;
    tick(1); sel(2'd0);
    check("rise_data_k", rd_dut, 32'd0);
    tick(1);
    check("rise_data_k1", rd_dut, 32'd1);
    sel(2'd3);
    check("rise_cap_k1", rd_dut, 32'd0);
    check("rise_irq_k1", {31'd0, irq_dut}, 32'd0);
    tick(1);
    check("rise_cap_k2", rd_dut, 32'd1);
    check("rise_irq_k2", {31'd0, irq_dut}, 32'd1);
    in_dut = 2'b00; tick(3);
    check("rise_cap_hold", rd_dut, 32'd1);
    check("rise_irq_hold", {31'd0, irq_dut}, 32'd1);
    sel(2'd0);
    check("fall_data", rd_dut, 32'd0);

    // W1C and set-over-clear collision
    in_dut = 2'b11; tick(3); sel(2'd3);
    check("cap_both", rd_dut, 32'd3);
    bus_write(2'd3, 32'd1);
    check("w1c_bit0", rd_dut, 32'd2);
    check("w1c_irq", {31'd0, irq_dut}, 32'd0);
    in_dut = 2'b10; tick(3);
    check("fall_keep", rd_dut, 32'd2);
    in_dut = 2'b11; tick(2);
    bus_write(2'd3, 32'd1);
    check("w1c_collide", rd_dut, 32'd3);
    check("collide_irq", {31'd0, irq_dut}, 32'd1);

    // Masking
    bus_write(2'd3, 32'd1);
    check("mask_cap", rd_dut, 32'd2);
    check("mask_irq_off", {31'd0, irq_dut}, 32'd0);
    bus_write(2'd2, 32'd2);
    check("mask_irq_on", {31'd0, irq_dut}, 32'd1);
    bus_write(2'd2, 32'd0);
    check("mask_irq_zero", {31'd0, irq_dut}, 32'd0);

    // Read-only and reserved registers
    bus_write(2'd0, 32'd0); sel(2'd0);
    check("data_ro", rd_dut, 32'd3);
    bus_write(2'd1, 32'hFFFF_FFFF); sel(2'd1);
    check("reserved", rd_dut, 32'd0);
    sel(2'd2);
    check("mask_untouched", rd_dut, 32'd0);

    // Debounce D=4: 3-cycle pulse rejected, 4-cycle pulse accepted
    bus_write(2'd3, 32'd3);
    in_deb = 2'b01; tick(3); in_deb = 2'b00; tick(6);
    sel(2'd0);
    check("deb_short_data", rd_deb, 32'd0);
    sel(2'd3);
    check("deb_short_cap", rd_deb, 32'd0);
    in_deb = 2'b01; tick(4); in_deb = 2'b00;
    tick(1); sel(2'd0);
    check("deb_data_k4", rd_deb, 32'd0);
    tick(1);
    check("deb_data_k5", rd_deb, 32'd1);
    sel(2'd3);
    check("deb_cap_k5", rd_deb, 32'd0);
    tick(1);
    check("deb_cap_k6", rd_deb, 32'd1);

    // Any-edge vs falling-edge capture on bit 1
    bus_write(2'd3, 32'd3);
    in_any = 2'b10; in_fall = 2'b10; tick(3); sel(2'd3);
    check("any_rise", rd_any, 32'd2);
    check("fall_rise_ignored", rd_fall, 32'd0);
    bus_write(2'd3, 32'd2);
    check("any_clr", rd_any, 32'd0);
    in_any = 2'b00; in_fall = 2'b00; tick(3);
    check("any_fall", rd_any, 32'd2);
    check("fall_fall", rd_fall, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
